fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 15 +
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction SRAM bus between the fetch unit (master) and the SRAM (slave).
// All strobes are active low; the fetch unit never writes.
interface fetch_unit_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_en_n;
  logic              mem_oe_n;
  logic              mem_we_n;

  modport master (output mem_addr, mem_en_n, mem_oe_n, mem_we_n, input  mem_rdata);
  modport slave  (input  mem_addr, mem_en_n, mem_oe_n, mem_we_n, output mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: streams sequential SRAM reads into a small FIFO, one access
// in flight at a time, with redirect flushing the FIFO and restarting the stream.
module fetch_unit #(
  parameter int              ADDR_W      = 18,
  parameter int              DATA_W      = 16,
  parameter int              WAIT_CYCLES = 1,
  parameter int              BUF_DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      mem,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic {IDLE, FETCH} state_e;

  state_e                          state_q, state_d;
  logic [ADDR_W-1:0]               fetch_pc_q, fetch_pc_d;
  logic [3:0]                      wait_q, wait_d;
  logic [CNT_W-1:0]                count_q, count_d, count_nxt;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [BUF_DEPTH-1:0][DATA_W-1:0] buf_inst_q, buf_inst_d;
  logic [BUF_DEPTH-1:0][ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic                            push, pop, room;

  assign push       = (state_q == FETCH) && (wait_q == 4'(WAIT_CYCLES));
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && !hold;
  assign count_nxt  = count_q + CNT_W'(push) - CNT_W'(pop);
  // A new access may only start if its data is guaranteed a free slot.
  assign room       = count_nxt < CNT_W'(BUF_DEPTH);

  assign mem.mem_addr = fetch_pc_q;
  assign mem.mem_en_n = (state_q != FETCH);
  assign mem.mem_oe_n = (state_q != FETCH);
  assign mem.mem_we_n = 1'b1;

  // While empty, inst_pc tracks the next fetch address so it reads RESET_PC
  // out of reset and the redirect target right after a redirect.
  assign inst    = inst_valid ? buf_inst_q[rd_ptr_q] : '0;
  assign inst_pc = inst_valid ? buf_pc_q[rd_ptr_q]   : fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wait_d     = wait_q;
    count_d    = count_nxt;
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;

    if (push) begin
      buf_inst_d[wr_ptr_q] = mem.mem_rdata;
      buf_pc_d[wr_ptr_q]   = fetch_pc_q;
    end

    case (state_q)
      IDLE: begin
        if (room) begin
          state_d = FETCH;
          wait_d  = '0;
        end
      end
      FETCH: begin
        if (push) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          wait_d     = '0;
          state_d    = room ? FETCH : IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
    endcase

    // Redirect overrides everything: the in-flight read is dropped and the
    // FIFO is emptied by clearing the count and pointers.
    if (redirect) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_pc;
      wait_d     = '0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      wait_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wait_q     <= wait_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_inst_q <= buf_inst_d;
    buf_pc_q   <= buf_pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard on the consumed instruction stream plus
// directed checks of bus timing, reset, redirect, wrap and WAIT_CYCLES=0.
module tb_fetch_unit;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;

  logic          hold0 = 1'b0;
  logic          redirect0 = 1'b0;
  logic [AW-1:0] redirect_pc0 = '0;
  logic          iv0;
  logic [DW-1:0] inst0;
  logic [AW-1:0] ipc0;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();
  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mbus0 ();

  // SRAM contents: word a holds a + 16'h100 (low 16 bits).
  assign mbus.mem_rdata  = 16'(mbus.mem_addr + 18'h100);
  assign mbus0.mem_rdata = 16'(mbus0.mem_addr + 18'h100);

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .BUF_DEPTH(2), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem(mbus), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc));

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .BUF_DEPTH(2), .RESET_PC('0)) dut0 (
    .clk(clk), .rst(rst), .hold(hold0), .redirect(redirect0), .redirect_pc(redirect_pc0),
    .mem(mbus0), .inst_valid(iv0), .inst(inst0), .inst_pc(ipc0));

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic exp_t mk(input logic [AW-1:0] pc, input logic [DW-1:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_en_n"}, mbus.mem_en_n, 1);
    chk({tag, "_oe_n"}, mbus.mem_oe_n, 1);
    chk({tag, "_we_n"}, mbus.mem_we_n, 1);
    chk({tag, "_addr"}, mbus.mem_addr, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
  endtask

  // Monitor: every consumed instruction must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && !redirect && inst_valid && !hold) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: unexpected inst_pc=%0h inst=%0h", inst_pc, inst);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_inst", inst, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int en_low;
    rst = 1'b1;
    repeat (2) tick();
    chk_reset_vals("rst");
    chk("rst0_valid", iv0, 0);
    chk("rst0_en_n", mbus0.mem_en_n, 1);

    // Free-running stream, hold=0.
    for (int i = 0; i < 5; i++) q.push_back(mk(AW'(i), 16'h100 + 16'(i)));
    rst = 1'b0;
    tick();
    chk("a_en_n", mbus.mem_en_n, 0);
    chk("a_oe_n", mbus.mem_oe_n, 0);
    chk("a_addr0", mbus.mem_addr, 0);
    chk("a_valid_p1", inst_valid, 0);
    chk("w0_addr_p1", mbus0.mem_addr, 0);
    for (int k = 2; k <= 11; k++) begin
      tick();
      if (k <= 8) begin
        chk("w0_addr", mbus0.mem_addr, k - 1);
        chk("w0_valid", iv0, 1);
        chk("w0_pc", ipc0, k - 2);
        chk("w0_inst", inst0, 32'h100 + k - 2);
      end
      if (k == 2) begin
        chk("a_valid_p2", inst_valid, 0);
        chk("a_addr_stable", mbus.mem_addr, 0);
      end
      if (k == 3) begin
        chk("a_first_valid", inst_valid, 1);
        chk("a_first_pc", inst_pc, 0);
        chk("a_next_addr", mbus.mem_addr, 1);
      end
      if (k == 11) begin
        chk("a_rate_valid", inst_valid, 1);
        chk("a_rate_pc", inst_pc, 4);
      end
    end
    tick();
    chk("a_drain", q.size(), 0);

    // Hold from reset: buffer fills after exactly two accesses.
    rst = 1'b1;
    hold = 1'b1;
    tick();
    rst = 1'b0;
    en_low = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (!mbus.mem_en_n) en_low++;
    end
    chk("b_access_cycles", en_low, 4);
    chk("b_idle_en_n", mbus.mem_en_n, 1);
    chk("b_full_valid", inst_valid, 1);
    chk("b_head_pc", inst_pc, 0);
    chk("b_idle_addr", mbus.mem_addr, 2);
    q.push_back(mk(18'h0, 16'h0100));
    hold = 1'b0;
    tick();
    hold = 1'b1;
    chk("b_pop_pc", inst_pc, 1);
    chk("b_restart_en_n", mbus.mem_en_n, 0);
    chk("b_restart_addr", mbus.mem_addr, 2);
    chk("b_drain", q.size(), 0);
    tick();

    // Redirect on the completing edge with hold=1; pc 2 data must vanish.
    redirect = 1'b1;
    redirect_pc = 18'h00100;
    q.delete();
    q.push_back(mk(18'h00100, 16'h0200));
    q.push_back(mk(18'h00101, 16'h0201));
    q.push_back(mk(18'h00102, 16'h0202));
    tick();
    redirect = 1'b0;
    hold = 1'b0;
    chk("c_empty", inst_valid, 0);
    chk("c_addr", mbus.mem_addr, 18'h00100);
    chk("c_en_n", mbus.mem_en_n, 0);
    tick();
    chk("c_wait_valid", inst_valid, 0);
    tick();
    chk("c_first_valid", inst_valid, 1);
    chk("c_first_pc", inst_pc, 18'h00100);
    repeat (5) tick();
    chk("c_drain", q.size(), 0);

    // Address wrap.
    redirect = 1'b1;
    redirect_pc = 18'h3FFFF;
    q.push_back(mk(18'h3FFFF, 16'h00FF));
    q.push_back(mk(18'h00000, 16'h0100));
    q.push_back(mk(18'h00001, 16'h0101));
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    chk("d_pc_top", inst_pc, 18'h3FFFF);
    chk("d_inst_top", inst, 16'h00FF);
    repeat (2) tick();
    chk("d_pc_wrap", inst_pc, 0);
    chk("d_inst_wrap", inst, 16'h0100);
    repeat (3) tick();
    chk("d_drain", q.size(), 0);

    // Reset during the wait cycle of the pc 2 access.
    rst = 1'b1;
    tick();
    chk_reset_vals("e_rst");
    rst = 1'b0;
    q.push_back(mk(18'h0, 16'h0100));
    q.push_back(mk(18'h1, 16'h0101));
    tick();
    chk("e_addr", mbus.mem_addr, 0);
    chk("e_en_n", mbus.mem_en_n, 0);
    chk("e_valid", inst_valid, 0);
    repeat (2) tick();
    chk("e_first_valid", inst_valid, 1);
    chk("e_first_pc", inst_pc, 0);
    repeat (3) tick();
    chk("e_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
